// File: rtl/parity_fifo_pkg.sv
// Shared constants and helpers for the parity-filtered FIFO.
package parity_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic check_bit_ok(input logic check_bit, input logic even_odd);
        return check_bit == even_odd;
    endfunction

endpackage

// File: rtl/parity_fifo_if.sv
// Producer/consumer handshake bundle; master drives the FIFO, slave is the FIFO itself.
interface parity_fifo_if
    import parity_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH:0] data_i;
    logic                valid_i;
    logic                grant_o;
    logic [DATA_WIDTH:0] data_o;
    logic                valid_o;
    logic                grant_i;

    modport master (
        output data_i, valid_i, grant_i,
        input  grant_o, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, grant_i,
        output grant_o, data_o, valid_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head; a wrap flag disambiguates full from empty.
module sync_fifo
    import parity_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WIDTH:0] push_data_i,
    input  logic                push_valid_i,
    output logic                push_grant_o,
    output logic [DATA_WIDTH:0] pop_data_o,
    output logic                pop_valid_o,
    input  logic                pop_grant_i
);
    localparam int            PW   = ptr_width(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH:0] my_ram [FIFO_DEPTH];
    logic [PW-1:0]       ptr_read;
    logic [PW-1:0]       ptr_write;
    logic                flag;
    logic                same, empty, full, push, pop, wrap_write, wrap_read;

    assign same       = (ptr_read == ptr_write);
    assign empty      = same && !flag;
    assign full       = same && flag;
    assign push       = push_valid_i && !full;
    assign pop        = pop_grant_i && !empty;
    assign wrap_write = push && (ptr_write == LAST);
    assign wrap_read  = pop && (ptr_read == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n && push)
            my_ram[ptr_write] <= push_data_i;
    end

    // The flag only flips when one pointer laps without the other.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_read  <= '0;
            ptr_write <= '0;
            flag      <= 1'b0;
        end else begin
            if (push)
                ptr_write <= ptr_write + 1'b1;
            if (pop)
                ptr_read <= ptr_read + 1'b1;
            flag <= flag ^ (wrap_write ^ wrap_read);
        end
    end

    assign pop_data_o   = my_ram[ptr_read];
    assign pop_valid_o  = !empty;
    assign push_grant_o = !full;
endmodule

// File: rtl/parity_fifo_top.sv
// FIFO with output-side check-bit filter; build with FIFO_PARITY_CHECK_EN to drop bad heads.
// rst_n is active-high despite its name.
module parity_fifo_top
    import parity_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    parity_fifo_if.slave    bus
);
    logic [DATA_WIDTH:0] head;
    logic                not_empty;
    logic                valid;
    logic                drop;
    logic                pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) fifo_i (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (bus.data_i),
        .push_valid_i (bus.valid_i),
        .push_grant_o (bus.grant_o),
        .pop_data_o   (head),
        .pop_valid_o  (not_empty),
        .pop_grant_i  (pop)
    );

`ifdef FIFO_PARITY_CHECK_EN
    // A bad head is discarded on its own, independent of the consumer.
    assign valid = not_empty && check_bit_ok(head[PARITY_BIT], 1'(EVEN_ODD));
    assign drop  = not_empty && !check_bit_ok(head[PARITY_BIT], 1'(EVEN_ODD));
`else
    assign valid = not_empty;
    assign drop  = 1'b0;
`endif

    assign pop         = (valid && bus.grant_i) || drop;
    assign bus.valid_o = valid;
    assign bus.data_o  = head;
endmodule

// File: tb/tb_parity_fifo_top.sv
// Scoreboard bench for parity_fifo_top; expectations follow FIFO_PARITY_CHECK_EN when defined.
module tb_parity_fifo_top;
    import parity_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   num_checks = 0;
    int   num_errors = 0;
    bit   mon_en     = 1'b0;

    logic [DW:0] model_q [$];
    logic [DW:0] exp_q   [$];

    parity_fifo_if #(.DATA_WIDTH(DW)) bus ();

    parity_fifo_top #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .EVEN_ODD   (0),
        .PARITY_BIT (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_good(input logic [DW:0] w);
`ifdef FIFO_PARITY_CHECK_EN
        return w[0] == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [DW:0] data, input logic valid, input logic grant);
        @(posedge clk);
        #1;
        bus.data_i  = data;
        bus.valid_i = valid;
        bus.grant_i = grant;
    endtask

    // Reference queue: advances on the same edges as the DUT using the inputs held since the last edge.
    always @(posedge clk) begin
        logic full, empty, good, pop, push;
        if (rst_n) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            full  = (model_q.size() == DEPTH);
            empty = (model_q.size() == 0);
            good  = !empty && model_good(model_q[0]);
            pop   = (good && bus.grant_i) || (!empty && !good);
            push  = bus.valid_i && !full;
            if (pop)
                void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(bus.data_i);
                if (model_good(bus.data_i))
                    exp_q.push_back(bus.data_i);
            end
        end
    end

    // Monitor: flags and delivered words are checked mid-cycle against the reference.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_valid;
            exp_valid = (model_q.size() != 0) && model_good(model_q[0]);
            check_output("grant_o", 64'(bus.grant_o), 64'(model_q.size() != DEPTH));
            check_output("valid_o", 64'(bus.valid_o), 64'(exp_valid));
            if (bus.valid_o && bus.grant_i) begin
                if (exp_q.size() == 0)
                    check_output("unexpected_delivery", 64'(bus.data_o), 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    check_output("data_o", 64'(bus.data_o), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n       = 1'b1;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.grant_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check_output("reset_ptr_read",  64'(dut.fifo_i.ptr_read),  64'd0);
        check_output("reset_ptr_write", 64'(dut.fifo_i.ptr_write), 64'd0);
        check_output("reset_flag",      64'(dut.fifo_i.flag),      64'd0);
        check_output("reset_valid_o",   64'(bus.valid_o),          64'd0);
        check_output("reset_grant_o",   64'(bus.grant_o),          64'd1);

        // Overflow: six pushes, only the first four fit.
        for (int i = 1; i <= 6; i++)
            apply_stimulus(33'(2 * i), 1'b1, 1'b0);
        apply_stimulus('0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("full_grant_o", 64'(bus.grant_o), 64'd0);
        check_output("full_head",    64'(bus.data_o),  64'h2);
        repeat (5) apply_stimulus('0, 1'b0, 1'b1);

        // Underflow: popping an empty FIFO must not move anything.
        repeat (6) apply_stimulus('0, 1'b0, 1'b1);
        @(negedge clk);
        check_output("underflow_ptr_read",  64'(dut.fifo_i.ptr_read),  64'd0);
        check_output("underflow_ptr_write", 64'(dut.fifo_i.ptr_write), 64'd0);
        check_output("underflow_flag",      64'(dut.fifo_i.flag),      64'd0);

        // Corrupt drop: 0x7 vanishes between 0x4 and 0xA.
        apply_stimulus(33'h4, 1'b1, 1'b1);
        apply_stimulus(33'h7, 1'b1, 1'b1);
        apply_stimulus(33'hA, 1'b1, 1'b1);
        repeat (4) apply_stimulus('0, 1'b0, 1'b1);

        // Concurrent traffic with repeated pointer wrap.
        for (int i = 1; i <= 30; i++)
            apply_stimulus(33'(3 * i), 1'b1, 1'b1);
        repeat (4) apply_stimulus('0, 1'b0, 1'b1);

        // Odd word with the consumer stalled.
        apply_stimulus(33'h7, 1'b1, 1'b0);
        apply_stimulus('0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef FIFO_PARITY_CHECK_EN
        check_output("odd_word_valid_o", 64'(bus.valid_o), 64'd0);
`else
        check_output("odd_word_valid_o", 64'(bus.valid_o), 64'd1);
        check_output("odd_word_data_o",  64'(bus.data_o),  64'h7);
`endif
        repeat (3) apply_stimulus('0, 1'b0, 1'b1);

        // Reset mid-operation discards stored words.
        apply_stimulus(33'h2, 1'b1, 1'b0);
        apply_stimulus(33'h4, 1'b1, 1'b0);
        apply_stimulus('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset_valid_o", 64'(bus.valid_o), 64'd0);
        check_output("midreset_grant_o", 64'(bus.grant_o), 64'd1);

        // Everything expected must come out within a bounded drain.
        begin
            int budget;
            budget = 20;
            bus.grant_i = 1'b1;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(negedge clk);
            check_output("drain_remaining", 64'(exp_q.size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
